// File: rtl/cla_pkg.sv
// Shared types and constants for the multi-precision CLA sequencer.
package cla_pkg;

  localparam int CLA_WORD = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} cla_seq_state_t;

  typedef logic [31:0] cla_word_t;

endpackage

// File: rtl/cla_32bits.sv
// 32-bit adder: per-bit generate/propagate with the carry recurrence
// c[i+1] = g[i] | p[i]&c[i], which synthesis flattens into lookahead logic.
module cla_32bits
  import cla_pkg::*;
(
  input  cla_word_t a,
  input  cla_word_t b,
  input  logic      ci,
  output cla_word_t s,
  output logic      co
);

  cla_word_t   g;
  cla_word_t   p;
  logic [32:0] c;

  // Generate/propagate terms and the carry chain feeding each sum bit.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < CLA_WORD; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    s  = p ^ c[31:0];
    co = c[32];
  end

endmodule

// File: rtl/cla_mp_sequencer.sv
// Multi-precision add/subtract: streams WORDS 32-bit words through one
// shared cla_32bits, LSW first, chaining the carry through a register.
module cla_mp_sequencer
  import cla_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CLA_WORD*WORDS-1:0] in_a,
  input  logic [CLA_WORD*WORDS-1:0] in_b,
  input  logic                    in_sub,
  input  logic                    in_ci,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CLA_WORD*WORDS-1:0] out_s,
  output logic                    out_co,
  output logic                    out_ovf,
  output logic                    busy
);

  localparam int W     = CLA_WORD * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  cla_seq_state_t   state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     s_q, s_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  cla_word_t a_word;
  cla_word_t b_word;
  cla_word_t sum_word;
  logic      co_word;

  assign a_word = a_q[idx_q*CLA_WORD +: CLA_WORD];
  assign b_word = b_q[idx_q*CLA_WORD +: CLA_WORD];

  cla_32bits u_cla (
    .a  (a_word),
    .b  (b_word),
    .ci (carry_q),
    .s  (sum_word),
    .co (co_word)
  );

  // State, operand, carry and result registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      co_q        <= co_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state: accept in IDLE, one word per RUN cycle, then register the result valid in DONE.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    co_d        = co_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub ? 1'b1 : in_ci;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[idx_q*CLA_WORD +: CLA_WORD] = sum_word;
        carry_d = co_word;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          co_d    = co_word;
          ovf_d   = (a_word[31] == b_word[31]) && (sum_word[31] != a_word[31]);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid_q) begin
          if (out_ready) begin
            state_d = IDLE;
          end else begin
            out_valid_d = 1'b1;
          end
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_valid = out_valid_q;
  assign out_s     = s_q;
  assign out_co    = co_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_mp_sequencer.sv
// Directed bench for cla_mp_sequencer: a WORDS=4 instance driven from a
// vector table plus hand sequences, and a WORDS=1 instance for latency 2.
module tb_cla_mp_sequencer;

  localparam logic [127:0] ALL1 = {128{1'b1}};

  typedef struct {
    string        name;
    logic [127:0] a;
    logic [127:0] b;
    logic         sub;
    logic         ci;
    logic [127:0] s;
    logic         co;
    logic         ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_a = '0;
  logic [127:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic         in_ci = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_s;
  logic         out_co;
  logic         out_ovf;
  logic         busy;

  logic         in1_valid = 1'b0;
  logic         in1_ready;
  logic [31:0]  in1_a = '0;
  logic [31:0]  in1_b = '0;
  logic         in1_sub = 1'b0;
  logic         in1_ci = 1'b0;
  logic         out1_valid;
  logic         out1_ready = 1'b0;
  logic [31:0]  out1_s;
  logic         out1_co;
  logic         out1_ovf;
  logic         busy1;

  int checks = 0;
  int errors = 0;

  vec_t vecs[9];

  cla_mp_sequencer #(.WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_ci     (in_ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_co    (out_co),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  cla_mp_sequencer #(.WORDS(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in1_valid),
    .in_ready  (in1_ready),
    .in_a      (in1_a),
    .in_b      (in1_b),
    .in_sub    (in1_sub),
    .in_ci     (in1_ci),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .out_s     (out1_s),
    .out_co    (out1_co),
    .out_ovf   (out1_ovf),
    .busy      (busy1)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one request to the WORDS=4 instance and waits (bounded) for out_valid.
  task automatic applyStimulus(input logic [127:0] a, input logic [127:0] b,
                               input logic sub, input logic ci, output int lat);
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_ci    = ci;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_sub   = ~sub;
    in_ci    = ~ci;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Completes the result handshake for the WORDS=4 instance.
  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Presents one request to the WORDS=1 instance and waits (bounded) for out1_valid.
  task automatic applyStimulus1(input logic [31:0] a, input logic [31:0] b,
                                input logic sub, input logic ci, output int lat);
    @(negedge clk);
    in1_a     = a;
    in1_b     = b;
    in1_sub   = sub;
    in1_ci    = ci;
    in1_valid = 1'b1;
    @(posedge clk);
    #1;
    in1_valid = 1'b0;
    lat = 0;
    while (!out1_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;

    vecs[0] = '{"add_c32",   128'hFFFF_FFFF, 128'h1, 1'b0, 1'b0,
                128'h1_0000_0000, 1'b0, 1'b0};
    vecs[1] = '{"ripple",    ALL1, 128'h0, 1'b0, 1'b1,
                128'h0, 1'b1, 1'b0};
    vecs[2] = '{"sub_neg",   128'h5, 128'h7, 1'b1, 1'b0,
                128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 1'b0, 1'b0};
    vecs[3] = '{"sub_pos",   128'h7, 128'h5, 1'b1, 1'b0,
                128'h2, 1'b1, 1'b0};
    vecs[4] = '{"add_ovf",   128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, 1'b0,
                128'h80000000_00000000_00000000_00000000, 1'b0, 1'b1};
    vecs[5] = '{"sub_ovf",   128'h80000000_00000000_00000000_00000000, 128'h1, 1'b1, 1'b0,
                128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b1, 1'b1};
    vecs[6] = '{"sub_noci",  128'hA, 128'h3, 1'b1, 1'b0,
                128'h7, 1'b1, 1'b0};
    vecs[7] = '{"add_ci3w",  128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h0, 1'b0, 1'b1,
                128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0};
    vecs[8] = '{"add_mix",   128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0,
                128'h11111111_11111111_11111111_11111111, 1'b0, 1'b0,
                128'h23456789_ABCDF001_20202021_02020201, 1'b0, 1'b0};

    // Reset values while rst_n is held low.
    #1;
    checkOutput("rst_in_ready",  128'(in_ready),  128'h1);
    checkOutput("rst_out_valid", 128'(out_valid), 128'h0);
    checkOutput("rst_out_s",     out_s,           128'h0);
    checkOutput("rst_out_co",    128'(out_co),    128'h0);
    checkOutput("rst_out_ovf",   128'(out_ovf),   128'h0);
    checkOutput("rst_busy",      128'(busy),      128'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of directed transactions.
    for (int i = 0; i < 9; i++) begin
      checkOutput({vecs[i].name, "_ready"}, 128'(in_ready), 128'h1);
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].ci, lat);
      checkOutput({vecs[i].name, "_lat"},  128'(lat),       128'd5);
      checkOutput({vecs[i].name, "_s"},    out_s,           vecs[i].s);
      checkOutput({vecs[i].name, "_co"},   128'(out_co),    128'(vecs[i].co));
      checkOutput({vecs[i].name, "_ovf"},  128'(out_ovf),   128'(vecs[i].ovf));
      checkOutput({vecs[i].name, "_busy"}, 128'(busy),      128'h1);
      releaseResult();
      checkOutput({vecs[i].name, "_idle"}, 128'(out_valid), 128'h0);
    end

    // Backpressure: result held for 10 cycles while a new request is offered.
    applyStimulus(vecs[0].a, vecs[0].b, vecs[0].sub, vecs[0].ci, lat);
    checkOutput("bp_lat", 128'(lat), 128'd5);
    in_a     = 128'h3;
    in_b     = 128'h4;
    in_sub   = 1'b0;
    in_ci    = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_valid", 128'(out_valid), 128'h1);
      checkOutput("bp_s",     out_s,           vecs[0].s);
      checkOutput("bp_co",    128'(out_co),    128'h0);
      checkOutput("bp_ready", 128'(in_ready),  128'h0);
    end
    in_valid = 1'b0;
    releaseResult();
    checkOutput("bp_rel_ready", 128'(in_ready),  128'h1);
    checkOutput("bp_rel_valid", 128'(out_valid), 128'h0);
    checkOutput("bp_rel_busy",  128'(busy),      128'h0);
    checkOutput("bp_rel_s",     out_s,           vecs[0].s);

    // Reset asserted during the second RUN cycle.
    @(negedge clk);
    in_a     = 128'h5;
    in_b     = 128'h6;
    in_sub   = 1'b0;
    in_ci    = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_busy_pre", 128'(busy), 128'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_s",     out_s,           128'h0);
    checkOutput("mid_ready", 128'(in_ready),  128'h1);
    checkOutput("mid_busy",  128'(busy),      128'h0);
    checkOutput("mid_valid", 128'(out_valid), 128'h0);
    checkOutput("mid_co",    128'(out_co),    128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(128'h3, 128'h4, 1'b0, 1'b0, lat);
    checkOutput("post_rst_lat", 128'(lat),    128'd5);
    checkOutput("post_rst_s",   out_s,        128'h7);
    checkOutput("post_rst_co",  128'(out_co), 128'h0);
    releaseResult();

    // WORDS=1 instance: single RUN cycle, latency 2.
    applyStimulus1(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    checkOutput("w1_lat", 128'(lat),      128'd2);
    checkOutput("w1_s",   128'(out1_s),   128'h0);
    checkOutput("w1_co",  128'(out1_co),  128'h1);
    checkOutput("w1_ovf", 128'(out1_ovf), 128'h0);
    out1_ready = 1'b1;
    @(posedge clk);
    #1;
    out1_ready = 1'b0;
    checkOutput("w1_ready", 128'(in1_ready), 128'h1);
    applyStimulus1(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    checkOutput("w1o_lat", 128'(lat),      128'd2);
    checkOutput("w1o_s",   128'(out1_s),   128'h8000_0000);
    checkOutput("w1o_ovf", 128'(out1_ovf), 128'h1);
    out1_ready = 1'b1;
    @(posedge clk);
    #1;
    out1_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
